// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [7:0] byte_t;

    localparam byte_t IDLE_BYTE_DEFAULT = 8'h00;

    // A one-entry range still needs a 1-bit index to form a legal port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating first-one finder: lowest set request at or above ptr_i, wrapping.
module rr_pick
    import uart_tx_pkg::*;
#(
    parameter int  N = 2,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found_o && req_i[j] && (((int'(ptr_i) + i) % N) == j)) begin
                    found_o = 1'b1;
                    idx_o   = W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_CH frame sources onto the UART transmit byte bus, paced by data_ready.
// Optional per-byte ready watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int    N_CH           = 2,
    parameter int    FRAME_BYTES    = 3,
    parameter int    ARB_MODE       = 0,
    parameter byte_t IDLE_BYTE      = IDLE_BYTE_DEFAULT,
    parameter int    CNT_W          = 8,
    parameter int    TIMEOUT_CYCLES = 4096,
    localparam int   SEL_W          = clog2_min1(N_CH),
    localparam int   IDX_W          = clog2_min1(FRAME_BYTES),
    localparam int   FW             = FRAME_BYTES * 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N_CH-1:0]      ch_req,
    input  logic [N_CH*FW-1:0]   ch_frame,
    input  logic                 data_ready,
    output logic [7:0]           data_send,
    output logic [N_CH-1:0]      ch_ack,
    output logic [N_CH-1:0]      ch_err,
    output logic                 busy,
    output logic [SEL_W-1:0]     active_ch,
    output logic [CNT_W-1:0]     frame_cnt
);

    state_e            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    byte_t             data_q, data_d;
    logic [N_CH-1:0]   ack_q, ack_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic [SEL_W-1:0]  act_q, act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  rr_q, rr_d;

    logic [SEL_W-1:0]  rr_idx, pick_idx, rr_next;
    logic              rr_found, pick_found;
    logic [FW-1:0]     frame_sel;
    byte_t             byte_next;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    function automatic logic [N_CH-1:0] ch_onehot(input logic [SEL_W-1:0] idx);
        logic [N_CH-1:0] oh;
        oh = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (idx == SEL_W'(c)) oh[c] = 1'b1;
        end
        return oh;
    endfunction

    rr_pick #(.N(N_CH)) u_rr_pick (
        .req_i   (ch_req),
        .ptr_i   (rr_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        if (ARB_MODE == 1) begin
            pick_found = rr_found;
            pick_idx   = rr_idx;
        end else if (N_CH == 1) begin
            pick_found = ch_req[0];
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (sel == SEL_W'(c) && ch_req[c]) begin
                    pick_found = 1'b1;
                    pick_idx   = SEL_W'(c);
                end
            end
        end

        frame_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (pick_idx == SEL_W'(c)) frame_sel = ch_frame[c*FW +: FW];
        end

        byte_next = IDLE_BYTE;
        for (int b = 0; b < FRAME_BYTES; b++) begin
            if (idx_q + 1'b1 == IDX_W'(b)) byte_next = frame_q[b*8 +: 8];
        end

        rr_next = (act_q == SEL_W'(N_CH - 1)) ? '0 : act_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = '0;
        act_d   = act_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SEND;
                    frame_d = frame_sel;
                    act_d   = pick_idx;
                    idx_d   = '0;
                    data_d  = frame_sel[7:0];
                end
            end
            SEND: begin
                if (data_ready) begin
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        // Ack, count and pointer update all become visible during the DONE cycle.
                        state_d = DONE;
                        ack_d   = ch_onehot(act_q);
                        cnt_d   = cnt_q + 1'b1;
                        data_d  = IDLE_BYTE;
                        if (ARB_MODE == 1) rr_d = rr_next;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = byte_next;
                    end
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    err_d   = ch_onehot(act_q);
                    data_d  = IDLE_BYTE;
                    if (ARB_MODE == 1) rr_d = rr_next;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign wdog_d = (state_q == SEND && !data_ready) ? wdog_q + 1'b1 : '0;

    always_ff @(posedge clock) begin
        if (reset) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= IDLE_BYTE;
            ack_q   <= '0;
            err_q   <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // The latched frame is pure data and is only meaningful while busy.
    always_ff @(posedge clock) begin
        frame_q <= frame_d;
    end

    assign data_send = data_q;
    assign ch_ack    = ack_q;
    assign ch_err    = err_q;
    assign busy      = (state_q != IDLE);
    assign active_ch = act_q;
    assign frame_cnt = cnt_q;

endmodule
